// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm, wait for trigger rising edge, delay, then burst samples into trace BRAM.
// Optional macro TRACE_DECIM_EN: each BRAM word is the sum of two consecutive samples.
module trace_capture_ctrl #(
    parameter int SAMPLE_W    = 7,
    parameter int ADDR_W      = 9,
    parameter int NUM_SAMPLES = 56,
    parameter int DELAY_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                trigger,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [7:0]          mem_wdata,
    output logic                busy,
    output logic                done
);

`ifdef TRACE_DECIM_EN
    localparam int SPAN = 2;
`else
    localparam int SPAN = 1;
`endif
    localparam int CNT_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  TOTAL     = CNT_W'(SPAN * NUM_SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

    if (NUM_SAMPLES < 1 || NUM_SAMPLES > (1 << ADDR_W)) begin : g_chk_num
        $error("trace_capture_ctrl: NUM_SAMPLES must be in 1..2**ADDR_W");
    end
    if (SAMPLE_W > 8) begin : g_chk_width
        $error("trace_capture_ctrl: SAMPLE_W must not exceed 8");
    end
`ifdef TRACE_DECIM_EN
    if (SAMPLE_W > 7) begin : g_chk_sum
        $error("trace_capture_ctrl: pair sum needs SAMPLE_W <= 7 to fit 8 bits");
    end
`endif

    // S_IDLE wait arm | S_ARMED wait trigger edge | S_DELAY count down | S_CAPTURE sample and write
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_DELAY   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               trig_d;
    logic               trig_edge;
    logic [DELAY_W-1:0] dly_cnt;
    logic [CNT_W-1:0]   smp_cnt;
    logic               take;
    logic               last_write;
`ifdef TRACE_DECIM_EN
    logic [SAMPLE_W-1:0] acc;
`endif

    assign trig_edge  = trigger & ~trig_d;
    assign last_write = mem_we && (mem_waddr == LAST_ADDR);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // take: sample_in is consumed this cycle; the entry cycle into CAPTURE already samples
    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trig_edge) begin
                    if (delay == '0) begin
                        state_next = S_CAPTURE;
                        take       = 1'b1;
                    end else begin
                        state_next = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (dly_cnt == DELAY_W'(1)) begin
                    state_next = S_CAPTURE;
                    take       = 1'b1;
                end
            end
            S_CAPTURE: begin
                take = (smp_cnt < TOTAL);
                if (last_write) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d    <= 1'b0;
            dly_cnt   <= '0;
            smp_cnt   <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
`ifdef TRACE_DECIM_EN
            acc       <= '0;
`endif
        end else begin
            trig_d <= trigger;
            mem_we <= 1'b0;

            if (state == S_IDLE && arm) begin
                done      <= 1'b0;
                mem_waddr <= '0;
                smp_cnt   <= '0;
            end

            if (state == S_ARMED && trig_edge) begin
                dly_cnt <= delay;
            end else if (state == S_DELAY) begin
                dly_cnt <= dly_cnt - DELAY_W'(1);
            end

            if (take) begin
                smp_cnt <= smp_cnt + CNT_W'(1);
`ifdef TRACE_DECIM_EN
                // even take holds the first sample of the pair, odd take writes the sum
                if (!smp_cnt[0]) begin
                    acc <= sample_in;
                end else begin
                    mem_we    <= 1'b1;
                    mem_wdata <= 8'(acc) + 8'(sample_in);
                end
`else
                mem_we    <= 1'b1;
                mem_wdata <= 8'(sample_in);
`endif
            end

            if (mem_we && mem_waddr != LAST_ADDR) begin
                mem_waddr <= mem_waddr + ADDR_W'(1);
            end

            if (state == S_CAPTURE && last_write) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl: vector table, directed corner sequences, random traffic vs timeline model.
module tb_trace_capture_ctrl;
    localparam int N = 56;
`ifdef TRACE_DECIM_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, arm, trigger;
    logic [7:0] delay;
    logic [6:0] sample_in;
    logic       mem_we;
    logic [8:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       busy, done;

    always #5 clk = ~clk;

    trace_capture_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .trigger   (trigger),
        .delay     (delay),
        .sample_in (sample_in),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] samp [0:16383];

    // Timeline model: phase 0 idle, 1 armed, 2 capture planned to start sampling at m_start
    int   m_phase = 0;
    int   m_start = 0;
    bit   m_done = 0;
    int   m_hold = 0;
    bit   m_valid = 0;
    bit   m_after_rst = 0;
    logic m_trig_prev = 1'b0;

    int         wr_count = 0;
    int         first_wr = -1;
    int         last_wr_cyc = 0;
    int         done_cyc = 0;
    logic       prev_done = 1'b0;
    logic [7:0] last_data = '0;

    typedef struct {
        logic       r, a, t;
        logic [7:0] d;
        logic [6:0] s;
        logic       we, bz, dn;
        logic [8:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mkv(input bit r, a, t, input int d, s,
                                 input bit we, bz, dn, input int addr, data);
        vec_t v;
        v.r = r; v.a = a; v.t = t; v.d = 8'(d); v.s = 7'(s);
        v.we = we; v.bz = bz; v.dn = dn; v.addr = 9'(addr); v.data = 8'(data);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input int c, input logic r, a, t, input logic [7:0] d);
        bit edge_now;
        edge_now = t && !m_trig_prev;
        if (r) begin
            m_phase = 0; m_done = 0; m_hold = 0; m_valid = 1; m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            case (m_phase)
                0: if (a) begin m_phase = 1; m_done = 0; m_hold = 0; end
                1: if (edge_now) begin m_start = c + int'(d); m_phase = 2; end
                2: if (c == m_start + L * N) begin m_phase = 0; m_done = 1; m_hold = N - 1; end
                default: m_phase = 0;
            endcase
        end
        m_trig_prev = r ? 1'b0 : t;
    endtask

    task automatic model_check(input int k);
        bit         inwin;
        logic [7:0] exp_data;
        if (!m_valid) return;
        inwin = (m_phase == 2) && (k > m_start) && (k <= m_start + L * N) && ((k - m_start) % L == 0);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_done);
        chk("we", mem_we, inwin);
        if (inwin) begin
`ifdef TRACE_DECIM_EN
            exp_data = 8'(samp[k-2]) + 8'(samp[k-1]);
`else
            exp_data = 8'(samp[k-1]);
`endif
            chk("addr", mem_waddr, (k - m_start) / L - 1);
            chk("data", mem_wdata, exp_data);
        end else if (m_phase != 2 || k <= m_start) begin
            chk("addr_hold", mem_waddr, m_hold);
        end
        if (m_after_rst) chk("wdata_rst", mem_wdata, 0);
    endtask

    task automatic step(input logic r, a, t, input logic [7:0] d, input logic [6:0] s);
        rst = r; arm = a; trigger = t; delay = d; sample_in = s;
        samp[cyc] = s;
        model_update(cyc, r, a, t, d);
        @(posedge clk);
        cyc++;
        #1;
        if (mem_we === 1'b1) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_data = mem_wdata;
            if (mem_waddr == 9'(N - 1)) last_wr_cyc = cyc;
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done = done;
        model_check(cyc);
    endtask

    task automatic step_h(input logic r, a, t, input logic [7:0] d);
        step(r, a, t, d, 7'(cyc % 128));
    endtask

    task automatic run_until_idle(input string name, input int budget, input logic t,
                                  input logic [6:0] fixs, input bit usefix);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1'b0, 1'b0, t, 8'd0, usefix ? fixs : 7'(cyc % 128));
            n++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int t3, t4, n;
        logic trig_r;

        tbl[0] = mkv(1, 1, 1, 0, 5,  0, 0, 0, 0, 0);
        tbl[1] = mkv(1, 1, 1, 0, 6,  0, 0, 0, 0, 0);
        tbl[2] = mkv(0, 0, 1, 0, 7,  0, 0, 0, 0, 0);
        tbl[3] = mkv(0, 1, 1, 0, 8,  0, 1, 0, 0, 0);
        tbl[4] = mkv(0, 0, 1, 0, 9,  0, 1, 0, 0, 0);
        tbl[5] = mkv(0, 0, 0, 0, 9,  0, 1, 0, 0, 0);
`ifdef TRACE_DECIM_EN
        tbl[6] = mkv(0, 0, 1, 0, 10, 0, 1, 0, 0, 0);
        tbl[7] = mkv(0, 0, 1, 0, 11, 1, 1, 0, 0, 21);
        tbl[8] = mkv(0, 0, 0, 0, 12, 0, 1, 0, 1, 0);
`else
        tbl[6] = mkv(0, 0, 1, 0, 10, 1, 1, 0, 0, 10);
        tbl[7] = mkv(0, 0, 1, 0, 11, 1, 1, 0, 1, 11);
        tbl[8] = mkv(0, 0, 0, 0, 12, 1, 1, 0, 2, 12);
`endif

        // reset with arm/trigger high, arm, trigger already high, edge with zero delay
        for (int v = 0; v < 9; v++) begin
            step(tbl[v].r, tbl[v].a, tbl[v].t, tbl[v].d, tbl[v].s);
            chk("tbl_we", mem_we, tbl[v].we);
            chk("tbl_busy", busy, tbl[v].bz);
            chk("tbl_done", done, tbl[v].dn);
            chk("tbl_addr", mem_waddr, tbl[v].addr);
            if (tbl[v].we || tbl[v].r) chk("tbl_data", mem_wdata, tbl[v].data);
        end
        run_until_idle("t2", 300, 1'b0, 7'd0, 1'b0);
        chk("t2_writes", wr_count, N);
        chk("t2_done_lat", done_cyc - last_wr_cyc, 1);

        // delay 5
        wr_count = 0; first_wr = -1;
        step_h(1'b0, 1'b1, 1'b0, 8'd0);
        step_h(1'b0, 1'b0, 1'b0, 8'd0);
        step_h(1'b0, 1'b0, 1'b0, 8'd0);
        t3 = cyc;
        step_h(1'b0, 1'b0, 1'b1, 8'd5);
        run_until_idle("t3", 400, 1'b1, 7'd0, 1'b0);
        chk("t3_first", first_wr, t3 + 5 + L);
        chk("t3_count", wr_count, N);
        chk("t3_done", done, 1);

        // trigger high before arm: needs fall then rise
        for (int i = 0; i < 3; i++) step_h(1'b0, 1'b0, 1'b1, 8'd0);
        wr_count = 0; first_wr = -1;
        step_h(1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) step_h(1'b0, 1'b0, 1'b1, 8'd0);
        step_h(1'b0, 1'b0, 1'b0, 8'd0);
        step_h(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4_nowrite", wr_count, 0);
        t4 = cyc;
        step_h(1'b0, 1'b0, 1'b1, 8'd3);
        run_until_idle("t4", 400, 1'b1, 7'd0, 1'b0);
        chk("t4_first", first_wr, t4 + 3 + L);

        // arm + edge mid-burst ignored, then reset mid-burst
        step_h(1'b0, 1'b0, 1'b0, 8'd0);
        wr_count = 0;
        step_h(1'b0, 1'b1, 1'b0, 8'd0);
        step_h(1'b0, 1'b0, 1'b1, 8'd0);
        n = 0;
        while (wr_count < 20 && n < 500) begin step_h(1'b0, 1'b0, 1'b0, 8'd0); n++; end
        step_h(1'b0, 1'b1, 1'b1, 8'd0);
        n = 0;
        while (wr_count < 30 && n < 500) begin step_h(1'b0, 1'b0, 1'b1, 8'd0); n++; end
        chk("t5_addr", mem_waddr, 29);
        step_h(1'b1, 1'b0, 1'b1, 8'd0);
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_done", done, 0);
        for (int i = 0; i < 3; i++) step_h(1'b0, 1'b0, 1'b0, 8'd0);

`ifdef TRACE_DECIM_EN
        wr_count = 0;
        step(1'b0, 1'b1, 1'b0, 8'd0, 7'd127);
        step(1'b0, 1'b0, 1'b1, 8'd2, 7'd127);
        run_until_idle("t6", 500, 1'b1, 7'd127, 1'b1);
        chk("t6_count", wr_count, N);
        chk("t6_data", last_data, 8'hFE);
        chk("t6_addr", mem_waddr, N - 1);
`endif

        // random traffic against the timeline model
        trig_r = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            logic       r, a;
            logic [7:0] d;
            r = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) trig_r = ~trig_r;
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            step(r, a, trig_r, d, 7'($urandom_range(0, 127)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
